lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
// Load/store control stage sitting between EXU and the DPI-backed data-memory block (MemRam).
// Accepts one memory op per handshake, checks alignment and encoding, issues a single-cycle
// isLoad/isStore strobe with addr/len/wdata, waits MEM_LATENCY cycles, then sign/zero-extends
// load data and returns a result (or error) to WBU through a valid/ready handshake.
// PARAMETERS
// XLEN         32  data/address width
// MEM_LATENCY  1   cycles from the issue cycle to rdata valid (>=1); rdata sampled at the last edge
// ALLOW_MISAL  0   1: misaligned accesses are issued; 0: misaligned -> resp_err, no memory access
// PORTS
// clock       in   1     single clock; all state updates on posedge
// reset       in   1     asynchronous, active-low reset (0 = in reset)
// req_valid   in   1     EXU presents a memory op
// req_ready   out  1     block can accept (high only in IDLE)
// req_store   in   1     1 = store, 0 = load
// req_funct3  in   3     RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// req_addr    in   XLEN  byte address
// req_wdata   in   XLEN  store data (rs2)
// mem_load    out  1     -> MemRam isLoad
// mem_store   out  1     -> MemRam isStore
// mem_addr    out  XLEN  -> MemRam addr
// mem_len     out  32    -> MemRam len (1, 2 or 4)
// mem_wdata   out  XLEN  -> MemRam wdata, zero-extended to len
// mem_rdata   in   XLEN  <- MemRam rdata (len bytes, zero-extended)
// resp_valid  out  1     result available to WBU
// resp_ready  in   1     WBU accepts result
// resp_rdata  out  XLEN  extended load data; 0 for stores; faulting address when resp_err
// resp_err    out  1     misaligned or illegal funct3
// BEHAVIOUR
// - Reset (async, on reset=0): state IDLE; req_ready=1 once released; mem_load/mem_store/resp_valid/
//   resp_err=0; mem_addr/mem_wdata/resp_rdata=0; mem_len=4; latency counter=0. Reset mid-op aborts
//   silently: strobes drop immediately, no response is ever produced for the aborted op.
// - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE. IDLE: accept on req_valid&&req_ready, latch all req fields.
//   Illegal (load funct3 011/110/111; store funct3 other than 000/001/010) or misaligned with
//   ALLOW_MISAL=0 (H: addr[0]!=0; W: addr[1:0]!=0) -> go straight to RESP with resp_err=1,
//   resp_rdata=req_addr, no strobe ever asserted.
// - ISSUE: exactly one cycle; mem_load xor mem_store=1; mem_addr/len/wdata stable from ISSUE through
//   the sampling edge. SB/SH: mem_wdata = req_wdata[7:0]/[15:0] zero-extended.
// - WAIT: counter runs MEM_LATENCY-1 further cycles (skipped when MEM_LATENCY=1); load data captured
//   at the edge ending the ISSUE+MEM_LATENCY-1 window; mem_rdata ignored at all other times.
// - Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passthrough. Stores return 0.
// - RESP: resp_valid=1, outputs held stable until resp_valid&&resp_ready, then IDLE (next req accepted
//   no earlier than the following cycle). Accept-to-resp_valid latency = 1+MEM_LATENCY cycles
//   (1 cycle for error responses). Backpressure may hold RESP indefinitely; no new strobe meanwhile.
// - One op in flight maximum; req_ready=0 in ISSUE/WAIT/RESP. Strobes never asserted outside ISSUE.
// STRUCTURE
// - lsu_pkg: state enum {IDLE,ISSUE,WAIT,RESP}; funct3 constants (F3_B/H/W/BU/HU); len constants.
// - Sub-module lsu_extend (combinational): funct3+raw data -> extended load data, store data mask,
//   mem_len, misaligned/illegal flags. lsu_ctrl holds FSM, latency counter, request/response regs.
// TESTING
// - LB addr=0x80000003, mem_rdata=0x000000F0 -> resp_rdata=0xFFFFFFF0, resp_valid 2 cycles after accept.
// - SH addr=0x80000002 wdata=0xDEADBEEF -> one-cycle mem_store, mem_len=2, mem_wdata=0x0000BEEF, resp_rdata=0.
// - LW addr=0x80000006 (ALLOW_MISAL=0) -> resp_err=1, resp_rdata=0x80000006 next cycle, mem_load never 1.
// - LHU mem_rdata=0x00008001 with resp_ready low 5 cycles -> resp_rdata=0x00008001 held, req_ready=0 throughout.
// - MEM_LATENCY=3, LW -> rdata sampled only at third edge after ISSUE start; earlier garbage ignored.
// - Assert reset=0 during WAIT -> strobes/resp_valid drop at once; after release first new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store control stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] LEN_B = 32'd1;
    localparam logic [31:0] LEN_H = 32'd2;
    localparam logic [31:0] LEN_W = 32'd4;

endpackage

// File: rtl/lsu_if.sv
// EXU request, MemRam access and WBU response signals of the load/store stage.
interface lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            mem_load;
    logic            mem_store;
    logic [XLEN-1:0] mem_addr;
    logic [31:0]     mem_len;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata, resp_ready,
        output req_ready, mem_load, mem_store, mem_addr, mem_len, mem_wdata,
               resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata, resp_ready,
        input  req_ready, mem_load, mem_store, mem_addr, mem_len, mem_wdata,
               resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_extend.sv
// Combinational decode of a memory op (length, store data, fault flags) and
// sign/zero extension of returned load data.
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            chk_store,
    input  logic [2:0]      chk_funct3,
    input  logic [1:0]      chk_addr_lo,
    input  logic [XLEN-1:0] chk_wdata,
    output logic [31:0]     len,
    output logic [XLEN-1:0] store_data,
    output logic            misaligned,
    output logic            illegal,
    input  logic [2:0]      ext_funct3,
    input  logic [XLEN-1:0] raw_data,
    output logic [XLEN-1:0] load_data
);

    always_comb begin
        len        = LEN_W;
        store_data = chk_wdata;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (chk_funct3)
            F3_B, F3_BU: begin
                len        = LEN_B;
                store_data = XLEN'(chk_wdata[7:0]);
            end
            F3_H, F3_HU: begin
                len        = LEN_H;
                store_data = XLEN'(chk_wdata[15:0]);
                misaligned = chk_addr_lo[0];
            end
            F3_W:    misaligned = |chk_addr_lo;
            default: illegal = 1'b1;
        endcase
        // Unsigned variants exist only for loads.
        if (chk_store && (chk_funct3 == F3_BU || chk_funct3 == F3_HU))
            illegal = 1'b1;
    end

    always_comb begin
        load_data = raw_data;
        case (ext_funct3)
            F3_B:    load_data = {{(XLEN-8){raw_data[7]}}, raw_data[7:0]};
            F3_H:    load_data = {{(XLEN-16){raw_data[15]}}, raw_data[15:0]};
            F3_BU:   load_data = XLEN'(raw_data[7:0]);
            F3_HU:   load_data = XLEN'(raw_data[15:0]);
            default: load_data = raw_data;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: accepts one op, strobes MemRam for a single cycle,
// waits out the memory latency and returns extended data or a fault to WBU.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MEM_LATENCY = 1,
    parameter bit          ALLOW_MISAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    lsu_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    state_t          state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [31:0]     len_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic [31:0]     len_c;
    logic [XLEN-1:0] store_data_c;
    logic [XLEN-1:0] load_data_c;
    logic            misal_c;
    logic            illegal_c;
    logic            fault_c;
    logic            accept;
    logic            sample;

    lsu_extend #(.XLEN(XLEN)) u_extend (
        .chk_store   (bus.req_store),
        .chk_funct3  (bus.req_funct3),
        .chk_addr_lo (bus.req_addr[1:0]),
        .chk_wdata   (bus.req_wdata),
        .len         (len_c),
        .store_data  (store_data_c),
        .misaligned  (misal_c),
        .illegal     (illegal_c),
        .ext_funct3  (funct3_q),
        .raw_data    (bus.mem_rdata),
        .load_data   (load_data_c)
    );

    assign accept  = bus.req_valid && (state == IDLE);
    assign fault_c = illegal_c || (misal_c && !ALLOW_MISAL);
    // The sampling edge closes the ISSUE cycle plus MEM_LATENCY-1 WAIT cycles.
    assign sample  = ((state == ISSUE) && (MEM_LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == CNT_W'(MEM_LATENCY - 1)));

    always_comb begin
        state_nx       = state;
        bus.req_ready  = 1'b0;
        bus.mem_load   = 1'b0;
        bus.mem_store  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) state_nx = fault_c ? RESP : ISSUE;
            end
            ISSUE: begin
                bus.mem_load  = !store_q;
                bus.mem_store = store_q;
                state_nx      = sample ? RESP : WAIT;
            end
            WAIT: if (sample) state_nx = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                if (bus.resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_len    = len_q;
    assign bus.resp_rdata = rdata_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            len_q    <= LEN_W;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                store_q  <= bus.req_store;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= store_data_c;
                len_q    <= len_c;
                err_q    <= fault_c;
                rdata_q  <= fault_c ? bus.req_addr : '0;
                cnt      <= '0;
            end
            if (state == ISSUE)
                cnt <= CNT_W'(1);
            else if (state == WAIT)
                cnt <= cnt + CNT_W'(1);
            if (sample)
                rdata_q <= store_q ? '0 : load_data_c;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with one-cycle and three-cycle memory latency.
module tb_lsu_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clock = ~clock;

    lsu_if #(.XLEN(32)) a_if ();
    lsu_if #(.XLEN(32)) b_if ();

    lsu_ctrl #(.XLEN(32), .MEM_LATENCY(1), .ALLOW_MISAL(1'b0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (a_if.slave)
    );

    lsu_ctrl #(.XLEN(32), .MEM_LATENCY(3), .ALLOW_MISAL(1'b0)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (b_if.slave)
    );

    typedef struct packed {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] len;
        logic [31:0] mwdata;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input int unsigned i, input vec_t v);
        string t;
        t = $sformatf("v%0d", i);
        a_if.req_valid  = 1'b1;
        a_if.req_store  = v.store;
        a_if.req_funct3 = v.f3;
        a_if.req_addr   = v.addr;
        a_if.req_wdata  = v.wdata;
        a_if.mem_rdata  = v.rdata;
        a_if.resp_ready = 1'b1;
        check({t, "_ready"}, a_if.req_ready, 1);
        tick();
        a_if.req_valid = 1'b0;
        if (v.err) begin
            check({t, "_err_strobe"}, a_if.mem_load | a_if.mem_store, 0);
            check({t, "_err_valid"}, a_if.resp_valid, 1);
            check({t, "_err_flag"}, a_if.resp_err, 1);
            check({t, "_err_addr"}, a_if.resp_rdata, v.addr);
        end else begin
            check({t, "_load"}, a_if.mem_load, !v.store);
            check({t, "_store"}, a_if.mem_store, v.store);
            check({t, "_addr"}, a_if.mem_addr, v.addr);
            check({t, "_len"}, a_if.mem_len, v.len);
            if (v.store) check({t, "_wdata"}, a_if.mem_wdata, v.mwdata);
            check({t, "_busy"}, a_if.req_ready, 0);
            check({t, "_early"}, a_if.resp_valid, 0);
            tick();
            a_if.mem_rdata = 32'hA5A5_5A5A;
            check({t, "_valid"}, a_if.resp_valid, 1);
            check({t, "_flag"}, a_if.resp_err, 0);
            check({t, "_rdata"}, a_if.resp_rdata, v.exp);
            check({t, "_nostrobe"}, a_if.mem_load | a_if.mem_store, 0);
        end
        tick();
        check({t, "_done"}, a_if.resp_valid, 0);
        check({t, "_idle"}, a_if.req_ready, 1);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 32'h8000_0003, 32'h0,         32'h0000_00F0, 1'b0, 32'd1, 32'h0,         32'hFFFF_FFF0};
        vecs[1]  = '{1'b1, 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'd2, 32'h0000_BEEF, 32'h0};
        vecs[2]  = '{1'b0, 3'b010, 32'h8000_0006, 32'h0,         32'h1111_1111, 1'b1, 32'd4, 32'h0,         32'h8000_0006};
        vecs[3]  = '{1'b0, 3'b001, 32'h8000_0002, 32'h0,         32'h0000_8001, 1'b0, 32'd2, 32'h0,         32'hFFFF_8001};
        vecs[4]  = '{1'b0, 3'b100, 32'h8000_0001, 32'h0,         32'h0000_00F0, 1'b0, 32'd1, 32'h0,         32'h0000_00F0};
        vecs[5]  = '{1'b1, 3'b000, 32'h8000_0005, 32'h1234_5678, 32'h0,         1'b0, 32'd1, 32'h0000_0078, 32'h0};
        vecs[6]  = '{1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_BABE, 32'h0,         1'b0, 32'd4, 32'hCAFE_BABE, 32'h0};
        vecs[7]  = '{1'b0, 3'b010, 32'h8000_000C, 32'h0,         32'h89AB_CDEF, 1'b0, 32'd4, 32'h0,         32'h89AB_CDEF};
        vecs[8]  = '{1'b0, 3'b011, 32'h8000_0010, 32'h0,         32'h0,         1'b1, 32'd4, 32'h0,         32'h8000_0010};
        vecs[9]  = '{1'b1, 3'b100, 32'h8000_0020, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'd1, 32'h0,         32'h8000_0020};
        vecs[10] = '{1'b1, 3'b001, 32'h8000_0001, 32'h0000_1234, 32'h0,         1'b1, 32'd2, 32'h0,         32'h8000_0001};
        vecs[11] = '{1'b0, 3'b001, 32'h8000_0004, 32'h0,         32'h0000_7FFF, 1'b0, 32'd2, 32'h0,         32'h0000_7FFF};

        a_if.req_valid = 1'b0; a_if.req_store = 1'b0; a_if.req_funct3 = '0;
        a_if.req_addr = '0; a_if.req_wdata = '0; a_if.mem_rdata = '0; a_if.resp_ready = 1'b1;
        b_if.req_valid = 1'b0; b_if.req_store = 1'b0; b_if.req_funct3 = '0;
        b_if.req_addr = '0; b_if.req_wdata = '0; b_if.mem_rdata = '0; b_if.resp_ready = 1'b1;

        #1 reset = 1'b0;
        #2;
        check("rst_ready", a_if.req_ready, 1);
        check("rst_strobe", a_if.mem_load | a_if.mem_store, 0);
        check("rst_valid", a_if.resp_valid, 0);
        check("rst_err", a_if.resp_err, 0);
        check("rst_addr", a_if.mem_addr, 0);
        check("rst_wdata", a_if.mem_wdata, 0);
        check("rst_rdata", a_if.resp_rdata, 0);
        check("rst_len", a_if.mem_len, 4);
        check("rst3_len", b_if.mem_len, 4);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        tick();

        for (int unsigned i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // LHU held under backpressure while a second request waits.
        a_if.req_valid = 1'b1; a_if.req_store = 1'b0; a_if.req_funct3 = 3'b101;
        a_if.req_addr = 32'h8000_0012; a_if.mem_rdata = 32'h0000_8001; a_if.resp_ready = 1'b0;
        tick();
        a_if.req_valid = 1'b0;
        check("hold_issue", a_if.mem_load, 1);
        tick();
        a_if.req_valid = 1'b1; a_if.req_funct3 = 3'b010; a_if.req_addr = 32'h8000_0040;
        a_if.mem_rdata = 32'hFFFF_FFFF;
        for (int unsigned k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_valid", k), a_if.resp_valid, 1);
            check($sformatf("hold%0d_rdata", k), a_if.resp_rdata, 32'h0000_8001);
            check($sformatf("hold%0d_ready", k), a_if.req_ready, 0);
            check($sformatf("hold%0d_strobe", k), a_if.mem_load | a_if.mem_store, 0);
            tick();
        end
        a_if.req_valid = 1'b0; a_if.resp_ready = 1'b1;
        tick();
        check("hold_release", a_if.resp_valid, 0);
        check("hold_idle", a_if.req_ready, 1);
        tick();
        check("hold_noaccept", a_if.mem_load | a_if.mem_store, 0);

        // Three-cycle latency: only the third edge after ISSUE start samples.
        b_if.req_valid = 1'b1; b_if.req_store = 1'b0; b_if.req_funct3 = 3'b010;
        b_if.req_addr = 32'h8000_0100; b_if.resp_ready = 1'b1;
        tick();
        b_if.req_valid = 1'b0;
        b_if.mem_rdata = 32'hBAD0_BAD0;
        check("lat3_issue", b_if.mem_load, 1);
        check("lat3_len", b_if.mem_len, 4);
        tick();
        b_if.mem_rdata = 32'hDEAD_0001;
        check("lat3_w1_strobe", b_if.mem_load, 0);
        check("lat3_w1_valid", b_if.resp_valid, 0);
        tick();
        b_if.mem_rdata = 32'h1122_3344;
        check("lat3_w2_valid", b_if.resp_valid, 0);
        check("lat3_w2_addr", b_if.mem_addr, 32'h8000_0100);
        tick();
        b_if.mem_rdata = 32'hDEAD_0002;
        check("lat3_valid", b_if.resp_valid, 1);
        check("lat3_rdata", b_if.resp_rdata, 32'h1122_3344);
        tick();
        check("lat3_done", b_if.resp_valid, 0);

        // Reset during WAIT aborts the op without a response.
        b_if.req_valid = 1'b1; b_if.req_addr = 32'h8000_0200; b_if.mem_rdata = 32'h5555_5555;
        tick();
        b_if.req_valid = 1'b0;
        tick();
        check("abort_wait", b_if.req_ready, 0);
        #2 reset = 1'b0;
        #1;
        check("abort_ready", b_if.req_ready, 1);
        check("abort_strobe", b_if.mem_load | b_if.mem_store, 0);
        check("abort_valid", b_if.resp_valid, 0);
        check("abort_addr", b_if.mem_addr, 0);
        tick();
        #3 reset = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            check($sformatf("abort_quiet%0d", k), b_if.resp_valid, 0);
        end
        b_if.req_valid = 1'b1; b_if.req_addr = 32'h8000_0300; b_if.mem_rdata = 32'hCAFE_F00D;
        tick();
        b_if.req_valid = 1'b0;
        check("post_issue", b_if.mem_load, 1);
        check("post_addr", b_if.mem_addr, 32'h8000_0300);
        repeat (3) tick();
        check("post_valid", b_if.resp_valid, 1);
        check("post_rdata", b_if.resp_rdata, 32'hCAFE_F00D);
        tick();
        check("post_done", b_if.resp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
